serial_adder_n_bits: RTL and testbench

Multi-cycle, parametrised add/subtract unit. It processes STEP bits of a WIDTH-bit operand pair per clock using a single STEP-bit adder slice and a rippled carry register. It generalises the team's combinational 8-bit ripple full adder into a sequential block with a start/done handshake, subtract mode and flag outputs. It sits in the datapath where area matters more than single-cycle latency.

---
 rtl/serial_adder_n_bits_if.sv | 26 ++
 rtl/serial_adder_n_bits.sv | 101 ++++++++++
 tb/tb_serial_adder_n_bits.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_n_bits_if.sv
// Operand/result bundle for the serial add/subtract unit.
// The master drives the request; the slave returns the handshake and the result flags.
interface serial_adder_n_bits_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, a, b, cin,
    input  busy, done, s, cout, ovf
  );

  modport slave (
    input  start, sub, a, b, cin,
    output busy, done, s, cout, ovf
  );
endinterface

// File: rtl/serial_adder_n_bits.sv
// Multi-cycle add/subtract: STEP bits per clock through one STEP-bit adder slice
// with a rippled carry register, start/done handshake and carry/overflow flags.
module serial_adder_n_bits #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned STEP  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  serial_adder_n_bits_if.slave    bus
);

  localparam int unsigned NSLICE = (STEP == 0) ? 1 : WIDTH / STEP;
  localparam int unsigned CNTW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  if ((STEP == 0) || (WIDTH < 2) || ((WIDTH % STEP) != 0)) begin : g_bad_param
    $error("serial_adder_n_bits: STEP must be nonzero and divide WIDTH, WIDTH >= 2");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] s_q;
  logic             carry_q;
  logic             busy_q;
  logic             done_q;
  logic             cout_q;
  logic             ovf_q;
  logic [CNTW-1:0]  cnt_q;

  logic [STEP:0]         slice_sum;
  logic [WIDTH+STEP-1:0] res_shift;
  logic                  last_slice;

  // Operands shift right each step, so the active slice is always the low STEP bits;
  // on the final step those bits hold the MSB slice, which gives the overflow signs.
  always_comb begin
    slice_sum  = {1'b0, a_q[STEP-1:0]} + {1'b0, b_q[STEP-1:0]} + {{STEP{1'b0}}, carry_q};
    res_shift  = {slice_sum[STEP-1:0], res_q};
    last_slice = (cnt_q == CNTW'(NSLICE - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            a_q     <= bus.a;
            b_q     <= bus.sub ? ~bus.b : bus.b;
            carry_q <= bus.sub ? 1'b1 : bus.cin;
            res_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= StRun;
          end
        end
        StRun: begin
          a_q     <= a_q >> STEP;
          b_q     <= b_q >> STEP;
          carry_q <= slice_sum[STEP];
          res_q   <= res_shift[WIDTH+STEP-1:STEP];
          cnt_q   <= cnt_q + CNTW'(1);
          if (last_slice) begin
            s_q     <= res_shift[WIDTH+STEP-1:STEP];
            cout_q  <= slice_sum[STEP];
            ovf_q   <= (a_q[STEP-1] == b_q[STEP-1]) && (slice_sum[STEP-1] != a_q[STEP-1]);
            done_q  <= 1'b1;
            state_q <= StDone;
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.s    = s_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder_n_bits.sv
// Bench for serial_adder_n_bits: three instances (8/1, 8/4, 16/2) checked against an
// arithmetic reference model with directed and random operations.
module tb_serial_adder_n_bits;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_adder_n_bits_if #(.WIDTH(8))  if_a ();
  serial_adder_n_bits_if #(.WIDTH(8))  if_b ();
  serial_adder_n_bits_if #(.WIDTH(16)) if_c ();

  serial_adder_n_bits #(.WIDTH(8), .STEP(1)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
  serial_adder_n_bits #(.WIDTH(8), .STEP(4)) dut_b (.clk(clk), .rst(rst), .bus(if_b));
  serial_adder_n_bits #(.WIDTH(16), .STEP(2)) dut_c (.clk(clk), .rst(rst), .bus(if_c));

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] last_s    [3];
  bit          last_cout [3];
  bit          last_ovf  [3];

  typedef struct {
    bit          sub;
    int unsigned a;
    int unsigned b;
    bit          cin;
    int unsigned es;
    bit          ecout;
    bit          eovf;
  } vec_t;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int unsigned width_of(input int which);
    return (which == 2) ? 16 : 8;
  endfunction

  function automatic int unsigned slices_of(input int which);
    return (which == 1) ? 2 : 8;
  endfunction

  // Reference: plain modular and signed arithmetic, no slicing.
  function automatic void model(input int unsigned w, input bit sub, input int unsigned a,
                                input int unsigned b, input bit cin, output int unsigned s,
                                output bit cout, output bit ovf);
    int unsigned m = 1 << w;
    int sa;
    int sb;
    int v;
    sa = (a >= m / 2) ? int'(a) - int'(m) : int'(a);
    sb = (b >= m / 2) ? int'(b) - int'(m) : int'(b);
    if (sub) begin
      s    = (a - b) & (m - 1);
      cout = (a >= b);
      v    = sa - sb;
    end else begin
      s    = (a + b + 32'(cin)) & (m - 1);
      cout = ((a + b + 32'(cin)) >= m);
      v    = sa + sb + int'(cin);
    end
    ovf = (v > int'(m / 2) - 1) || (v < -int'(m / 2));
  endfunction

  task automatic set_in(input int which, input bit start, input bit sub, input int unsigned a,
                        input int unsigned b, input bit cin);
    case (which)
      0: begin if_a.start = start; if_a.sub = sub; if_a.a = 8'(a); if_a.b = 8'(b); if_a.cin = cin; end
      1: begin if_b.start = start; if_b.sub = sub; if_b.a = 8'(a); if_b.b = 8'(b); if_b.cin = cin; end
      default: begin
        if_c.start = start; if_c.sub = sub; if_c.a = 16'(a); if_c.b = 16'(b); if_c.cin = cin;
      end
    endcase
  endtask

  task automatic set_start(input int which, input bit v);
    case (which)
      0: if_a.start = v;
      1: if_b.start = v;
      default: if_c.start = v;
    endcase
  endtask

  task automatic get_out(input int which, output bit busy, output bit done, output logic [15:0] s,
                         output bit cout, output bit ovf);
    case (which)
      0: begin busy = if_a.busy; done = if_a.done; s = {8'h0, if_a.s}; cout = if_a.cout; ovf = if_a.ovf; end
      1: begin busy = if_b.busy; done = if_b.done; s = {8'h0, if_b.s}; cout = if_b.cout; ovf = if_b.ovf; end
      default: begin
        busy = if_c.busy; done = if_c.done; s = if_c.s; cout = if_c.cout; ovf = if_c.ovf;
      end
    endcase
  endtask

  task automatic clear_last();
    for (int i = 0; i < 3; i++) begin
      last_s[i] = '0; last_cout[i] = 1'b0; last_ovf[i] = 1'b0;
    end
  endtask

  // Called at a negedge while the DUT is idle; returns at the negedge after acceptance.
  task automatic launch(input int which, input bit sub, input int unsigned a, input int unsigned b,
                        input bit cin);
    set_in(which, 1'b1, sub, a, b, cin);
    @(negedge clk);
  endtask

  // Called at the first negedge after acceptance; follows the operation to DONE.
  task automatic finish_check(input int which, input int unsigned es, input bit ecout,
                              input bit eovf, input bit disturb, input bit keep_start);
    int unsigned n = slices_of(which);
    int cyc = 0;
    int busyc = 0;
    bit seen = 1'b0;
    bit hold_ok = 1'b1;
    bit busy, done, cout, ovf;
    logic [15:0] s;
    while (!seen && cyc < 64) begin
      get_out(which, busy, done, s, cout, ovf);
      cyc++;
      if (busy) busyc++;
      if (done) begin
        seen = 1'b1;
      end else begin
        if (s !== last_s[which] || cout !== last_cout[which] || ovf !== last_ovf[which])
          hold_ok = 1'b0;
        if (disturb) begin
          if (cyc == 1) set_in(which, 1'b1, 1'b0, 1, 1, 1'b0);
          else set_in(which, 1'($urandom), 1'($urandom), $urandom, $urandom, 1'($urandom));
        end
        @(negedge clk);
      end
    end
    check_eq("done_seen", 32'(seen), 32'd1);
    check_eq("latency", cyc, n + 1);
    check_eq("busy_cycles", busyc, n + 1);
    check_eq("no_partial", 32'(hold_ok), 32'd1);
    check_eq("s", 32'(s), es);
    check_eq("cout", 32'(cout), 32'(ecout));
    check_eq("ovf", 32'(ovf), 32'(eovf));
    last_s[which] = 16'(es); last_cout[which] = ecout; last_ovf[which] = eovf;
    if (!keep_start) begin
      set_start(which, 1'b0);
      @(negedge clk);
      get_out(which, busy, done, s, cout, ovf);
      check_eq("busy_after", 32'(busy), 32'd0);
      check_eq("done_pulse", 32'(done), 32'd0);
    end
  endtask

  task automatic run_op(input int which, input vec_t v, input bit disturb);
    launch(which, v.sub, v.a, v.b, v.cin);
    if (!disturb) set_start(which, 1'b0);
    finish_check(which, v.es, v.ecout, v.eovf, disturb, 1'b0);
  endtask

  vec_t directed [6] = '{
    '{1'b0, 32'h88, 32'h26, 1'b0, 32'hAE, 1'b0, 1'b0},
    '{1'b0, 32'hFF, 32'h01, 1'b0, 32'h00, 1'b1, 1'b0},
    '{1'b0, 32'hC3, 32'h3C, 1'b1, 32'h00, 1'b1, 1'b0},
    '{1'b0, 32'h7F, 32'h01, 1'b0, 32'h80, 1'b0, 1'b1},
    '{1'b1, 32'h10, 32'h01, 1'b0, 32'h0F, 1'b1, 1'b0},
    '{1'b1, 32'h80, 32'h01, 1'b0, 32'h7F, 1'b1, 1'b1}
  };

  initial begin
    bit busy, done, cout, ovf;
    logic [15:0] s;
    int dones;
    vec_t v;
    for (int i = 0; i < 3; i++) set_in(i, 1'b0, 1'b0, 0, 0, 1'b0);
    clear_last();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      get_out(i, busy, done, s, cout, ovf);
      check_eq("rst_busy", 32'(busy), 0);
      check_eq("rst_done", 32'(done), 0);
      check_eq("rst_s", 32'(s), 0);
      check_eq("rst_cout", 32'(cout), 0);
      check_eq("rst_ovf", 32'(ovf), 0);
    end
    rst = 1'b0;

    foreach (directed[i]) run_op(0, directed[i], 1'b0);

    // Reset three RUN edges into an operation: abort, no DONE.
    launch(0, 1'b0, 32'h88, 32'h26, 1'b0);
    set_start(0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    clear_last();
    get_out(0, busy, done, s, cout, ovf);
    check_eq("abort_busy", 32'(busy), 0);
    check_eq("abort_s", 32'(s), 0);
    dones = int'(done);
    repeat (12) begin
      @(negedge clk);
      get_out(0, busy, done, s, cout, ovf);
      dones += int'(done) + int'(busy);
    end
    check_eq("abort_quiet", dones, 0);
    v = '{1'b0, 32'h98, 32'h36, 1'b0, 32'hCE, 1'b0, 1'b0};
    run_op(0, v, 1'b0);

    // Reset and START in the same cycle: nothing accepted.
    set_in(0, 1'b1, 1'b0, 32'h11, 32'h22, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    set_start(0, 1'b0);
    clear_last();
    @(negedge clk);
    get_out(0, busy, done, s, cout, ovf);
    check_eq("rst_start_busy", 32'(busy), 0);

    // START pulses and operand changes mid-run are ignored.
    v = '{1'b0, 32'h88, 32'h26, 1'b0, 32'hAE, 1'b0, 1'b0};
    run_op(0, v, 1'b1);

    // START held high: re-accepted on the first IDLE edge after DONE.
    launch(0, 1'b0, 32'h12, 32'h34, 1'b0);
    finish_check(0, 32'h46, 1'b0, 1'b0, 1'b0, 1'b1);
    set_in(0, 1'b1, 1'b0, 32'h55, 32'h11, 1'b0);
    @(negedge clk);
    get_out(0, busy, done, s, cout, ovf);
    check_eq("held_idle_gap", 32'(busy), 0);
    @(negedge clk);
    set_start(0, 1'b0);
    finish_check(0, 32'h66, 1'b0, 1'b0, 1'b0, 1'b0);

    v = '{1'b0, 32'h99, 32'h77, 1'b0, 32'h10, 1'b1, 1'b0};
    run_op(1, v, 1'b0);
    v = '{1'b0, 32'hFFFF, 32'h0001, 1'b0, 32'h0000, 1'b1, 1'b0};
    run_op(2, v, 1'b0);

    for (int w = 0; w < 3; w++) begin
      for (int k = 0; k < 12; k++) begin
        int unsigned m = (1 << width_of(w)) - 1;
        v.sub = 1'($urandom);
        v.a   = $urandom & m;
        v.b   = $urandom & m;
        v.cin = 1'($urandom);
        model(width_of(w), v.sub, v.a, v.b, v.cin, v.es, v.ecout, v.eovf);
        run_op(w, v, 1'($urandom_range(0, 3) == 0));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
